// File: rtl/tx_prbs31_data_generator_if.sv
// Control and data bundle of the PRBS31 transmit generator.
// The bench drives it through master; the generator uses slave.
interface tx_prbs31_data_generator_if #(
  parameter int WCNT_W = 48
);
  logic              enable;
  logic              seed_load;
  logic [30:0]       seed;
  logic              inject;
  logic [31:0]       DataOut;
  logic              data_valid;
  logic              inject_pending;
  logic [WCNT_W-1:0] Word_Count;
  logic [15:0]       Inject_Count;

  modport master (
    output enable, seed_load, seed, inject,
    input  DataOut, data_valid, inject_pending, Word_Count, Inject_Count
  );

  modport slave (
    input  enable, seed_load, seed, inject,
    output DataOut, data_valid, inject_pending, Word_Count, Inject_Count
  );
endinterface

// File: rtl/tx_prbs31_data_generator.sv
// Parallel PRBS31 (x^31 + x^28 + 1) word source with seed load, pause/resume
// and single-shot error injection that leaves the LFSR sequence untouched.
module tx_prbs31_data_generator #(
  parameter logic [30:0] DEFAULT_SEED = 31'h7FFF_FFFF,
  parameter logic [31:0] ERR_MASK     = 32'h0000_0001,
  parameter int          WCNT_W       = 48
) (
  input  logic                   clock,
  input  logic                   reset,
  tx_prbs31_data_generator_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state;
  logic [30:0] history;
  logic [31:0] next_word;
  logic        pend_now;

  // Unrolls s[n] = s[n-31] ^ s[n-28] over the 63-bit window {history, word};
  // bits are produced oldest first, so later bits may reuse fresh ones.
  function automatic logic [31:0] prbs_step(input logic [30:0] s);
    logic [62:0] d;
    d = {s, 32'd0};
    for (int j = 31; j >= 0; j--) begin
      d[j] = d[j+31] ^ d[j+28];
    end
    return d[31:0];
  endfunction

  always_comb begin
    next_word = prbs_step(history);
    pend_now  = bus.inject_pending | bus.inject;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      history            <= DEFAULT_SEED;
      bus.DataOut        <= 32'd0;
      bus.data_valid     <= 1'b0;
      bus.inject_pending <= 1'b0;
      bus.Word_Count     <= '0;
      bus.Inject_Count   <= 16'd0;
    end else if (bus.seed_load) begin
      state              <= IDLE;
      history            <= (bus.seed == 31'd0) ? 31'h7FFF_FFFF : bus.seed;
      bus.DataOut        <= 32'd0;
      bus.data_valid     <= 1'b0;
      bus.inject_pending <= 1'b0;
      bus.Word_Count     <= '0;
    end else if (bus.enable) begin
      // History always advances from the clean word; only the output is corrupted.
      state          <= RUN;
      history        <= next_word[30:0];
      bus.DataOut    <= pend_now ? (next_word ^ ERR_MASK) : next_word;
      bus.data_valid <= 1'b1;
      bus.Word_Count <= bus.Word_Count + WCNT_W'(1);
      if (pend_now) begin
        bus.inject_pending <= 1'b0;
        if (bus.Inject_Count != 16'hFFFF) begin
          bus.Inject_Count <= bus.Inject_Count + 16'd1;
        end
      end
    end else begin
      bus.data_valid     <= 1'b0;
      bus.inject_pending <= pend_now;
      if (state == RUN) begin
        state <= HOLD;
      end
    end
  end

endmodule

// File: tb/tb_tx_prbs31_data_generator.sv
// Directed bench for tx_prbs31_data_generator: serial golden LFSR model,
// expected-word scoreboard and an independent recurrence checker.
module tb_tx_prbs31_data_generator;

  localparam logic [30:0] DEFAULT_SEED = 31'h7FFF_FFFF;
  localparam logic [31:0] ERR_MASK     = 32'h0000_0001;
  localparam int          WCNT_W       = 48;

  logic clock;
  logic reset;

  tx_prbs31_data_generator_if #(.WCNT_W(WCNT_W)) bus ();

  tx_prbs31_data_generator #(
    .DEFAULT_SEED(DEFAULT_SEED),
    .ERR_MASK    (ERR_MASK),
    .WCNT_W      (WCNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  logic [30:0]       m_s;
  logic [31:0]       m_data;
  logic              m_valid;
  logic              m_pend;
  logic [WCNT_W-1:0] m_wc;
  logic [15:0]       m_ic;
  logic [31:0]       exp_q[$];

  logic [31:0] prev_word;
  logic        have_prev;
  int          viol;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Serial reference: shift one bit at a time through a 31-bit register.
  function automatic logic [31:0] golden_word(input logic [30:0] s_in);
    logic [30:0] s;
    logic [31:0] w;
    logic        b;
    s = s_in;
    w = 32'd0;
    for (int k = 0; k < 32; k++) begin
      b = s[30] ^ s[27];
      s = {s[29:0], b};
      w = {w[30:0], b};
    end
    return w;
  endfunction

  function automatic int recurrence_errors(input logic [31:0] p, input logic [31:0] w);
    logic [63:0] d;
    int n;
    d = {p, w};
    n = 0;
    for (int j = 0; j < 32; j++) begin
      if (d[j] !== (d[j+31] ^ d[j+28])) n++;
    end
    return n;
  endfunction

  task automatic checkOutput();
    logic [31:0] e;
    check("data_valid",     64'(bus.data_valid),     64'(m_valid));
    check("DataOut",        64'(bus.DataOut),        64'(m_data));
    check("inject_pending", 64'(bus.inject_pending), 64'(m_pend));
    check("Word_Count",     64'(bus.Word_Count),     64'(m_wc));
    check("Inject_Count",   64'(bus.Inject_Count),   64'(m_ic));
    if (bus.data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("sb_word", 64'(bus.DataOut), 64'(e));
      end
      if (have_prev) viol += recurrence_errors(prev_word, bus.DataOut);
      prev_word = bus.DataOut;
      have_prev = 1'b1;
    end
    check("sb_leftover", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic sl,
                               input logic [30:0] sd, input logic inj);
    logic [31:0] w;
    if (rst) begin
      m_s = DEFAULT_SEED; m_data = 0; m_valid = 0; m_pend = 0; m_wc = 0; m_ic = 0;
      have_prev = 1'b0;
    end else if (sl) begin
      m_s = (sd == 31'd0) ? 31'h7FFF_FFFF : sd;
      m_data = 0; m_valid = 0; m_pend = 0; m_wc = 0;
      have_prev = 1'b0;
    end else if (en) begin
      w   = golden_word(m_s);
      m_s = w[30:0];
      if (m_pend || inj) begin
        w = w ^ ERR_MASK;
        if (m_ic != 16'hFFFF) m_ic = m_ic + 16'd1;
      end
      m_pend  = 1'b0;
      m_data  = w;
      m_valid = 1'b1;
      m_wc    = m_wc + WCNT_W'(1);
      exp_q.push_back(w);
    end else begin
      m_valid = 1'b0;
      m_pend  = m_pend | inj;
    end
    reset         = rst;
    bus.enable    = en;
    bus.seed_load = sl;
    bus.seed      = sd;
    bus.inject    = inj;
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 31'd0, 1'b0);
  endtask

  task automatic pause(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 31'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; bus.enable = 0; bus.seed_load = 0; bus.seed = 0; bus.inject = 0;
    viol = 0; have_prev = 1'b0; prev_word = 0;

    $display("[TB] reset and seed 7FFFFFFF");
    applyStimulus(1'b1, 1'b0, 1'b0, 31'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 31'd0, 1'b0);
    check("reset_DataOut", 64'(bus.DataOut), 64'(0));
    applyStimulus(1'b0, 1'b0, 1'b1, 31'h7FFF_FFFF, 1'b0);
    run(1);
    check("first_word", 64'(bus.DataOut), 64'h0000_000E);
    check("first_count", 64'(bus.Word_Count), 64'(1));

    $display("[TB] 10000-word run");
    run(9999);
    check("run_viol", 64'(viol), 64'(0));
    check("run_count", 64'(bus.Word_Count), 64'(10000));

    $display("[TB] single injection during run");
    applyStimulus(1'b0, 1'b1, 1'b0, 31'd0, 1'b1);
    run(5);
    check("inject_viol", 64'(viol), 64'(3));
    check("inject_count", 64'(bus.Inject_Count), 64'(1));
    check("inject_pending_clr", 64'(bus.inject_pending), 64'(0));

    $display("[TB] pause 5 cycles and resume");
    pause(5);
    run(20);
    check("pause_viol", 64'(viol), 64'(3));

    $display("[TB] seed 0 with enable");
    applyStimulus(1'b0, 1'b1, 1'b1, 31'd0, 1'b0);
    check("load_wins_valid", 64'(bus.data_valid), 64'(0));
    run(1);
    check("seed0_first_word", 64'(bus.DataOut), 64'h0000_000E);
    run(8);

    $display("[TB] merged injections in HOLD");
    viol = 0;
    pause(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 31'd0, 1'b1);
    pause(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 31'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 31'd0, 1'b1);
    check("hold_pending", 64'(bus.inject_pending), 64'(1));
    run(6);
    check("hold_inject_count", 64'(bus.Inject_Count), 64'(2));
    check("hold_viol", 64'(viol), 64'(3));

    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 1'b1, 1'b0, 31'd0, 1'b1);
    check("midreset_zero", 64'({bus.DataOut, bus.data_valid, bus.inject_pending}), 64'(0));
    check("midreset_counts", 64'(bus.Word_Count) | 64'(bus.Inject_Count), 64'(0));
    run(1);
    check("midreset_first_word", 64'(bus.DataOut), 64'h0000_000E);
    run(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
